// File: rtl/noc_traffic_pkg.sv
// Shared definitions for NoC traffic sources and sinks: mode codes,
// the generator FSM encoding and the 16-bit Galois LFSR polynomial.
package noc_traffic_pkg;

  localparam int MODE_TABLE   = 0;
  localparam int MODE_UNIFORM = 1;
  localparam int MODE_HOTSPOT = 2;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/noc_lfsr16.sv
// 16-bit Galois LFSR with a loadable seed; shared by traffic sources and sinks.
module noc_lfsr16
  import noc_traffic_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  // Reload the seed on reset, otherwise step once per enabled cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/par_traffic_source.sv
// Destination-addressed flit generator for one router local port.
// A flit is built from the current LFSR value when the injection test fires,
// held until the router takes it (busy=0), then the source returns to IDLE.
// The destination table is supplied as a packed parameter, entry i at
// TABLE[i*ADDR_BITS +: ADDR_BITS].
module par_traffic_source
  import noc_traffic_pkg::*;
#(
  parameter int                             ID           = 0,
  parameter int                             NUM_NODES    = 16,
  parameter int                             ADDR_BITS    = 4,
  parameter int                             PAYLOAD_SIZE = 16,
  parameter int                             MODE         = 0,
  parameter int                             DESTS        = 1,
  parameter logic [NUM_NODES*ADDR_BITS-1:0] TABLE        = '0,
  parameter int                             REPEAT       = 1,
  parameter logic [8:0]                     PIR          = 9'd16,
  parameter int                             HOTSPOT      = 0,
  parameter int                             HOT_PCT      = 64,
  parameter int unsigned                    MAX_PKTS     = 0,
  parameter logic [15:0]                    SEED         = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               send,
  input  logic                               busy,
  output logic [PAYLOAD_SIZE+ADDR_BITS-1:0]  item_out,
  output logic                               valid,
  output logic                               done,
  output logic [31:0]                        tx_count,
  output logic [31:0]                        stall_count
);

  localparam int SEQ_W = PAYLOAD_SIZE - ADDR_BITS;
  localparam int IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam logic [ADDR_BITS-1:0] ID_A     = ADDR_BITS'(ID);
  localparam logic [ADDR_BITS-1:0] ID_NEXT  = ADDR_BITS'((ID + 1) % NUM_NODES);
  localparam logic [ADDR_BITS-1:0] HOT_A    = ADDR_BITS'(HOTSPOT);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DESTS - 1);

  state_t                            r_state, w_state_next;
  logic [PAYLOAD_SIZE+ADDR_BITS-1:0] r_item;
  logic [SEQ_W-1:0]                  r_seq;
  logic [IDX_W-1:0]                  r_idx;
  logic [31:0]                       r_tx_count, r_stall_count;

  logic [15:0]          w_lfsr;
  logic [7:0]           w_rnd;
  logic                 w_fire;
  logic [ADDR_BITS-1:0] w_uni_raw, w_rand_raw, w_rand_dest, w_tbl_dest, w_dest;
  logic [ADDR_BITS-1:0] w_mem [NUM_NODES];
  logic                 w_tbl_skip, w_last_idx, w_pass_end;
  logic                 w_budget_hit, w_done_cond, w_accept;
  logic                 w_load, w_skip;

  noc_lfsr16 #(
    .SEED (SEED ^ 16'(ID))
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .i_en    (1'b1),
    .o_state (w_lfsr)
  );

  // Unpack the destination table into an addressable array
  for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_tbl
    assign w_mem[gi] = TABLE[gi*ADDR_BITS +: ADDR_BITS];
  end

  // Injection test and destination selection from the current LFSR value
  assign w_rnd       = w_lfsr[15:8];
  assign w_fire      = ({1'b0, w_lfsr[7:0]} < PIR);
  assign w_uni_raw   = ADDR_BITS'(32'(w_rnd) % 32'(NUM_NODES));
  assign w_rand_raw  = ((MODE == MODE_HOTSPOT) && (32'(w_rnd) < 32'(HOT_PCT))) ? HOT_A : w_uni_raw;
  // A random destination never targets this node; bump it to the neighbour
  assign w_rand_dest = (w_rand_raw == ID_A) ? ID_NEXT : w_rand_raw;
  assign w_tbl_dest  = w_mem[r_idx];
  assign w_tbl_skip  = (MODE == MODE_TABLE) && (w_tbl_dest == ID_A);
  assign w_dest      = (MODE == MODE_TABLE) ? w_tbl_dest : w_rand_dest;

  // Terminal conditions: budget used up, or one-shot table pass finished
  assign w_last_idx   = (r_idx == LAST_IDX);
  assign w_pass_end   = (MODE == MODE_TABLE) && (REPEAT == 0) && w_last_idx;
  assign w_budget_hit = (MAX_PKTS != 0) && (({1'b0, r_tx_count} + 33'd1) == 33'(MAX_PKTS));
  assign w_done_cond  = (MAX_PKTS != 0) && (r_tx_count >= 32'(MAX_PKTS));
  assign w_accept     = (r_state == HOLD) && !busy;

  // Next-state logic; a self-addressed table entry is consumed without emitting
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_skip       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (send && w_fire && !w_done_cond) begin
          if (w_tbl_skip) begin
            w_skip = 1'b1;
            if (w_pass_end) begin
              w_state_next = DONE;
            end
          end else begin
            w_load       = 1'b1;
            w_state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (!busy) begin
          w_state_next = (w_budget_hit || w_pass_end) ? DONE : IDLE;
        end
      end
      DONE: begin
        w_state_next = DONE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Flit capture, sequence/table bookkeeping and saturating statistics
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_item        <= '0;
      r_seq         <= '0;
      r_idx         <= '0;
      r_tx_count    <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_load) begin
        r_item <= {ID_A, r_seq, w_dest};
      end
      if (w_accept) begin
        r_seq <= r_seq + SEQ_W'(1);
        if (r_tx_count != '1) begin
          r_tx_count <= r_tx_count + 32'd1;
        end
      end
      if (w_accept || w_skip) begin
        r_idx <= w_last_idx ? '0 : r_idx + IDX_W'(1);
      end
      if ((r_state == HOLD) && busy && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign item_out    = r_item;
  assign valid       = (r_state == HOLD);
  assign done        = (r_state == DONE);
  assign tx_count    = r_tx_count;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_par_traffic_source.sv
// Bench for par_traffic_source: five instances in different modes run side by
// side against a cycle model built from the generator's rules, plus directed
// scenario checks with hand-computed values.
module tb_par_traffic_source;

  localparam int N = 5;

  typedef struct {
    int id, mode, dests, rep, pir, hot, hpct, maxp;
  } cfg_t;

  typedef struct {
    logic [15:0] lfsr;
    bit          holding;
    bit          finished;
    logic [19:0] flit;
    int          seq;
    int          idx;
    longint      tx;
    longint      stall;
  } mdl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic send_tab = 1'b0, busy_tab = 1'b0;
  logic send_uni = 1'b0, busy_uni = 1'b0;
  logic send_off = 1'b0, busy_off = 1'b0;
  logic send_hot = 1'b0, busy_hot = 1'b0;
  logic send_max = 1'b0, busy_max = 1'b0;

  logic [19:0] item_o  [N];
  logic        valid_o [N];
  logic        done_o  [N];
  logic [31:0] tx_o    [N];
  logic [31:0] st_o    [N];

  int   total = 0;
  int   bad   = 0;
  int   tbl [4] = '{3, 5, 0, 7};
  cfg_t cfg [N];
  mdl_t m   [N];

  par_traffic_source #(.ID(5), .MODE(0), .DESTS(4), .TABLE(64'h7053), .REPEAT(0), .PIR(9'd256)) u_tab (
    .clk(clk), .reset(reset), .send(send_tab), .busy(busy_tab), .item_out(item_o[0]),
    .valid(valid_o[0]), .done(done_o[0]), .tx_count(tx_o[0]), .stall_count(st_o[0]));
  par_traffic_source #(.ID(2), .MODE(1), .PIR(9'd256)) u_uni (
    .clk(clk), .reset(reset), .send(send_uni), .busy(busy_uni), .item_out(item_o[1]),
    .valid(valid_o[1]), .done(done_o[1]), .tx_count(tx_o[1]), .stall_count(st_o[1]));
  par_traffic_source #(.ID(7), .MODE(1), .PIR(9'd0)) u_off (
    .clk(clk), .reset(reset), .send(send_off), .busy(busy_off), .item_out(item_o[2]),
    .valid(valid_o[2]), .done(done_o[2]), .tx_count(tx_o[2]), .stall_count(st_o[2]));
  par_traffic_source #(.ID(0), .MODE(2), .HOTSPOT(3), .HOT_PCT(192), .PIR(9'd256)) u_hot (
    .clk(clk), .reset(reset), .send(send_hot), .busy(busy_hot), .item_out(item_o[3]),
    .valid(valid_o[3]), .done(done_o[3]), .tx_count(tx_o[3]), .stall_count(st_o[3]));
  par_traffic_source #(.ID(1), .MODE(1), .MAX_PKTS(5), .PIR(9'd256)) u_max (
    .clk(clk), .reset(reset), .send(send_max), .busy(busy_max), .item_out(item_o[4]),
    .valid(valid_o[4]), .done(done_o[4]), .tx_count(tx_o[4]), .stall_count(st_o[4]));

  task automatic chk(input string nm, input int k, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, k, act, exp);
    end
  endtask

  // One clock of the generator's behaviour, written from its rules
  function automatic mdl_t step(input cfg_t c, input mdl_t cur, input logic rst_n,
                                input logic snd, input logic bsy);
    mdl_t n;
    int   r;
    int   d;
    bit   last;
    n = cur;
    if (!rst_n) begin
      n.lfsr = 16'hACE1 ^ 16'(c.id);
      n.holding = 0; n.finished = 0; n.flit = '0;
      n.seq = 0; n.idx = 0; n.tx = 0; n.stall = 0;
      return n;
    end
    n.lfsr = cur.lfsr[0] ? ((cur.lfsr >> 1) ^ 16'hB400) : (cur.lfsr >> 1);
    r    = int'(cur.lfsr[15:8]);
    last = (cur.idx == c.dests - 1);
    if (cur.holding) begin
      if (bsy) begin
        if (cur.stall < 64'hFFFF_FFFF) n.stall = cur.stall + 1;
      end else begin
        n.holding = 0;
        if (cur.tx < 64'hFFFF_FFFF) n.tx = cur.tx + 1;
        n.seq = (cur.seq + 1) % 4096;
        n.idx = last ? 0 : cur.idx + 1;
        if ((c.maxp != 0 && cur.tx + 1 == longint'(c.maxp)) || (c.mode == 0 && c.rep == 0 && last))
          n.finished = 1;
      end
    end else if (!cur.finished && snd && int'(cur.lfsr[7:0]) < c.pir) begin
      if (c.mode == 0) begin
        d = tbl[cur.idx];
      end else begin
        d = (c.mode == 2 && r < c.hpct) ? c.hot : r % 16;
        if (d == c.id) d = (c.id + 1) % 16;
      end
      if (c.mode == 0 && d == c.id) begin
        n.idx = last ? 0 : cur.idx + 1;
        if (c.rep == 0 && last) n.finished = 1;
      end else begin
        n.holding = 1;
        n.flit = {4'(c.id), 12'(cur.seq), 4'(d)};
      end
    end
    return n;
  endfunction

  task automatic upd(input int k, input logic s, input logic b);
    if (reset && m[k].holding && !b)
      $display("##,tx,%0d,%0d", m[k].flit[3:0], cfg[k].id);
    m[k] = step(cfg[k], m[k], reset, s, b);
  endtask

  // Model advances on every rising edge with the same inputs the DUTs see
  initial begin
    forever begin
      @(posedge clk);
      upd(0, send_tab, busy_tab);
      upd(1, send_uni, busy_uni);
      upd(2, send_off, busy_off);
      upd(3, send_hot, busy_hot);
      upd(4, send_max, busy_max);
    end
  end

  // Compare every instance against the model once per cycle, mid-period
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        chk("valid", k, longint'(valid_o[k]), longint'(m[k].holding));
        chk("done",  k, longint'(done_o[k]),  longint'(m[k].finished));
        chk("tx",    k, longint'(tx_o[k]),    m[k].tx);
        chk("stall", k, longint'(st_o[k]),    m[k].stall);
        if (m[k].holding) chk("item", k, longint'(item_o[k]), longint'(m[k].flit));
      end
    end
  end

  initial begin
    logic [19:0] first_f;
    int          w;
    cfg[0] = '{5, 0, 4, 0, 256, 0, 64,  0};
    cfg[1] = '{2, 1, 1, 1, 256, 0, 64,  0};
    cfg[2] = '{7, 1, 1, 1, 0,   0, 64,  0};
    cfg[3] = '{0, 2, 1, 1, 256, 3, 192, 0};
    cfg[4] = '{1, 1, 1, 1, 256, 0, 64,  5};
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk("rst_valid", k, longint'(valid_o[k]), 0);
      chk("rst_done",  k, longint'(done_o[k]),  0);
      chk("rst_tx",    k, longint'(tx_o[k]),    0);
      chk("rst_stall", k, longint'(st_o[k]),    0);
      chk("rst_item",  k, longint'(item_o[k]),  0);
    end
    reset = 1'b1;

    fork
      begin : t_tab
        int seen[$];
        int exp_d[3] = '{3, 0, 7};
        send_tab = 1'b1; busy_tab = 1'b0;
        for (int i = 0; i < 40 && !done_o[0]; i++) begin
          @(negedge clk);
          if (valid_o[0]) seen.push_back(int'(item_o[0][3:0]));
        end
        chk("tab_count", 0, seen.size(), 3);
        for (int i = 0; i < 3; i++)
          chk("tab_dest", i, (i < seen.size()) ? seen[i] : -1, exp_d[i]);
        chk("tab_done", 0, longint'(done_o[0]), 1);
        chk("tab_tx",   0, longint'(tx_o[0]),   3);
        send_tab = 1'b0;
      end
      begin : t_uni
        logic [19:0] held;
        int          wu;
        send_uni = 1'b1; busy_uni = 1'b1; wu = 0;
        @(negedge clk);
        while (!valid_o[1] && wu < 20) begin @(negedge clk); wu++; end
        chk("uni_valid_up", 1, longint'(valid_o[1]), 1);
        held = item_o[1];
        chk("uni_first_flit", 1, longint'(held), 20'h2000C);
        for (int i = 1; i <= 10; i++) begin
          @(negedge clk);
          chk("uni_hold", i, longint'(item_o[1]), longint'(held));
        end
        chk("uni_stall10", 1, longint'(st_o[1]), 10);
        chk("uni_still_valid", 1, longint'(valid_o[1]), 1);
        busy_uni = 1'b0;
        @(negedge clk);
        chk("uni_tx_after", 1, longint'(tx_o[1]), 1);
        chk("uni_released", 1, longint'(valid_o[1]), 0);
        send_uni = 1'b0;
        repeat (20) @(negedge clk);
        chk("uni_one_accept", 1, longint'(tx_o[1]), 1);
      end
      begin : t_off
        int nv;
        nv = 0; send_off = 1'b1; busy_off = 1'b0;
        repeat (1000) begin
          @(negedge clk);
          if (valid_o[2]) nv++;
        end
        chk("off_valid_cycles", 2, nv, 0);
        chk("off_tx", 2, longint'(tx_o[2]), 0);
        send_off = 1'b0;
      end
      begin : t_hot
        int          acc, hot, self_hits, wh;
        logic [19:0] hfirst;
        acc = 0; hot = 0; self_hits = 0; wh = 0; hfirst = '1;
        send_hot = 1'b1; busy_hot = 1'b0;
        while (acc < 4000 && wh < 9000) begin
          @(negedge clk);
          wh++;
          if (valid_o[3]) begin
            if (acc == 0) hfirst = item_o[3];
            acc++;
            if (item_o[3][3:0] == 4'd3) hot++;
            if (item_o[3][3:0] == 4'd0) self_hits++;
          end
        end
        chk("hot_first_flit", 3, longint'(hfirst), 20'h00003);
        chk("hot_accepts", 3, acc, 4000);
        chk("hot_share_in_72_78pct", 3, longint'(hot * 100 >= 72 * acc && hot * 100 <= 78 * acc), 1);
        chk("hot_self_dest", 3, self_hits, 0);
        send_hot = 1'b0;
      end
      begin : t_max
        int          seqs[$];
        logic [19:0] mfirst;
        mfirst = '1;
        send_max = 1'b1; busy_max = 1'b0;
        repeat (40) begin
          @(negedge clk);
          if (valid_o[4]) begin
            if (seqs.size() == 0) mfirst = item_o[4];
            seqs.push_back(int'(item_o[4][15:4]));
          end
        end
        chk("max_first_flit", 4, longint'(mfirst), 20'h1000C);
        chk("max_count", 4, seqs.size(), 5);
        for (int i = 0; i < 5; i++)
          chk("max_seq", i, (i < seqs.size()) ? seqs[i] : -1, i);
        chk("max_done",  4, longint'(done_o[4]),  1);
        chk("max_tx",    4, longint'(tx_o[4]),    5);
        chk("max_valid", 4, longint'(valid_o[4]), 0);
        send_max = 1'b0;
      end
    join

    // Reset while a flit is being held
    send_uni = 1'b1; busy_uni = 1'b1; w = 0;
    @(negedge clk);
    while (!valid_o[1] && w < 20) begin @(negedge clk); w++; end
    chk("rh_pre_valid", 1, longint'(valid_o[1]), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("rh_valid", 1, longint'(valid_o[1]), 0);
    chk("rh_tx",    1, longint'(tx_o[1]),    0);
    chk("rh_stall", 1, longint'(st_o[1]),    0);
    reset = 1'b1; busy_uni = 1'b0; w = 0;
    @(negedge clk);
    while (!valid_o[1] && w < 20) begin @(negedge clk); w++; end
    first_f = item_o[1];
    chk("rh_seq0",  1, longint'(first_f[15:4]), 0);
    chk("rh_flit",  1, longint'(first_f), 20'h2000C);
    send_uni = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
